// File: rtl/frame_store_ctrl_pkg.sv
// Shared encodings, default frame geometry and pixel packing for the
// passport-photo frame buffer controller.
package frame_store_ctrl_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 400;

  typedef enum logic [2:0] {
    FSM_IDLE     = 3'd0,
    FSM_PREVIEW  = 3'd1,
    SAVE_TO_BRAM = 3'd2,
    SHOW_BRAM    = 3'd3,
    SEND_TO_PC   = 3'd4
  } fsm_state_e;

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'd0,
    CAPTURE_FRAME = 2'd1,
    WRITING_FRAME = 2'd2,
    READING_FRAME = 2'd3
  } bram_state_e;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_WAIT  = 3'd2,
    TX_SEND  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  // RGB888 -> RGB332 keeps the top bits of each channel
  function automatic logic [7:0] pack_rgb332(input logic [23:0] rgb);
    return {rgb[23:21], rgb[15:13], rgb[7:6]};
  endfunction

endpackage

// File: rtl/frame_store_ctrl_tx_seq.sv
// Streams the frame buffer byte-by-byte to the serial sender with a
// fetch / wait / send handshake per byte.
module frame_tx_seq
  import frame_store_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int N_PIX  = 256000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              tx_ready,
  input  logic [7:0]        bram_dout,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  tx_state_e         state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= TX_IDLE;
      addr  <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
    end
  end

  // addr_next is handed straight to the BRAM address register, so the byte
  // for a new address is already on bram_dout while we sit in TX_WAIT
  always_comb begin
    state_next = state;
    addr_next  = addr;
    if (!en) begin
      state_next = TX_IDLE;
      addr_next  = '0;
    end else begin
      case (state)
        TX_IDLE:  state_next = TX_FETCH;
        TX_FETCH: state_next = TX_WAIT;
        TX_WAIT:  state_next = TX_SEND;
        TX_SEND: begin
          if (tx_ready) begin
            if (addr == LAST_ADDR) begin
              state_next = TX_DONE;
            end else begin
              state_next = TX_FETCH;
              addr_next  = addr + 1'b1;
            end
          end
        end
        TX_DONE:  state_next = TX_DONE;
        default:  state_next = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid = (state == TX_SEND);
    rd_addr  = addr_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data <= '0;
      tx_done <= 1'b0;
    end else begin
      if (state == TX_WAIT) tx_data <= bram_dout;
      tx_done <= en && (state == TX_SEND) && tx_ready && (addr == LAST_ADDR);
    end
  end

endmodule

// File: rtl/frame_store_ctrl.sv
// Frame buffer sequencer: captures one active frame into the BRAM, then
// serves it to VGA readback and, on request, to the serial sender.
module frame_store_ctrl
  import frame_store_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        fsm_state,
  input  logic              store_bram,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [23:0]       pixel_rgb,
  input  logic [7:0]        bram_dout,
  input  logic              tx_ready,
  output logic [1:0]        bram_state,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic              in_display,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_done
);

  localparam int N_PIX = H_ACTIVE * V_ACTIVE;

  bram_state_e       state, state_next;
  logic              store_prev, active, frame_start, last_pix;
  logic              write_now, tx_sel, tx_en, disp_pipe;
  logic [ADDR_W-1:0] pix_cnt, pix_addr, tx_addr, addr_next;

  assign active      = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign frame_start = (hcount == '0) && (vcount == '0);
  assign last_pix    = (hcount == 11'(H_ACTIVE - 1)) && (vcount == 10'(V_ACTIVE - 1));
  // one running counter serves both capture and readback: restart at (0,0)
  assign pix_addr    = frame_start ? '0 : pix_cnt;
  assign bram_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BRAM_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != BRAM_IDLE && !store_bram) begin
      state_next = BRAM_IDLE;
    end else begin
      case (state)
        BRAM_IDLE:
          if (store_bram && !store_prev && fsm_state == SAVE_TO_BRAM)
            state_next = CAPTURE_FRAME;
        CAPTURE_FRAME: if (frame_start) state_next = WRITING_FRAME;
        WRITING_FRAME: if (last_pix)    state_next = READING_FRAME;
        default:       state_next = state;
      endcase
    end
  end

  always_comb begin
    write_now = store_bram && active &&
                ((state == WRITING_FRAME) || (state == CAPTURE_FRAME && frame_start));
    tx_sel    = (state == READING_FRAME) && (fsm_state == SEND_TO_PC);
    tx_en     = tx_sel && store_bram;
    addr_next = tx_sel ? tx_addr : pix_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_prev <= 1'b0;
      pix_cnt    <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      disp_pipe  <= 1'b0;
      in_display <= 1'b0;
    end else begin
      store_prev <= store_bram;
      if (active) pix_cnt <= pix_addr + 1'b1;
      bram_we    <= write_now;
      bram_addr  <= addr_next;
      bram_din   <= pack_rgb332(pixel_rgb);
      disp_pipe  <= (state == READING_FRAME) && active && !tx_sel;
      in_display <= disp_pipe;
    end
  end

  frame_tx_seq #(
    .ADDR_W (ADDR_W),
    .N_PIX  (N_PIX)
  ) u_tx_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (tx_en),
    .tx_ready  (tx_ready),
    .bram_dout (bram_dout),
    .rd_addr   (tx_addr),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

endmodule

// File: tb/tb_frame_store_ctrl.sv
// Bench for frame_store_ctrl on a reduced 16x6 frame: random pixels and
// handshakes checked against a frame-level model of buffer and byte stream.
`timescale 1ns/1ps
module tb_frame_store_ctrl;
  import frame_store_ctrl_pkg::*;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int HT = 20;
  localparam int VT = 8;
  localparam int AW = 18;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    fsm_state;
  logic          store_bram;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [23:0]   pixel_rgb;
  logic [7:0]    bram_dout;
  logic          tx_ready;
  logic [1:0]    bram_state;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic          bram_we, in_display, tx_valid, tx_done;
  logic [7:0]    tx_data;

  int total = 0;
  int bad = 0;
  int cur_h = 0;
  int cur_v = 0;
  int done_pulses = 0;
  logic       load_req = 1'b0;
  logic [7:0] mem      [N];
  logic [7:0] load_buf [N];
  logic [7:0] exp_mem  [N];

  frame_store_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .fsm_state(fsm_state), .store_bram(store_bram),
    .hcount(hcount), .vcount(vcount), .pixel_rgb(pixel_rgb), .bram_dout(bram_dout),
    .tx_ready(tx_ready), .bram_state(bram_state), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_we(bram_we), .in_display(in_display),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // single-port BRAM with one cycle read latency; load_req bulk-preloads it
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= load_buf[i];
    end else if (bram_we && int'(bram_addr) < N) begin
      mem[int'(bram_addr)] <= bram_din;
    end
    bram_dout <= (int'(bram_addr) < N) ? mem[int'(bram_addr)] : 8'h00;
  end

  always @(negedge clk) if (tx_done === 1'b1) done_pulses++;

  function automatic logic [7:0] rgb332(input logic [23:0] p);
    return {p[23:21], p[15:13], p[7:6]};
  endfunction

  function automatic logic [23:0] rand_pix();
    return 24'($urandom());
  endfunction

  function automatic bit is_active(input int h, input int v);
    return (h < H) && (v < V);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input logic [23:0] pix, output int h, output int v);
    h = cur_h;
    v = cur_v;
    hcount = 11'(cur_h);
    vcount = 10'(cur_v);
    pixel_rgb = pix;
    tick();
    cur_h++;
    if (cur_h == HT) begin
      cur_h = 0;
      cur_v = (cur_v + 1) % VT;
    end
  endtask

  task automatic load_mem(input bit random_fill);
    for (int i = 0; i < N; i++) load_buf[i] = random_fill ? 8'($urandom()) : 8'(i);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    fsm_state = FSM_IDLE; store_bram = 1'b0; tx_ready = 1'b0;
    hcount = '0; vcount = '0; pixel_rgb = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({bram_state, bram_addr, bram_din, bram_we, in_display, tx_valid, tx_data, tx_done} !==
        {BRAM_IDLE, {AW{1'b0}}, 8'h00, 4'b0000, 8'h00, 1'b0})
      begin bad++; $display("[TB] FAIL reset_values got state=%0d addr=%0d din=%h we=%b disp=%b txv=%b txd=%h done=%b want all zero",
                            bram_state, bram_addr, bram_din, bram_we, in_display, tx_valid, tx_data, tx_done); end
    reset_n = 1'b1;
    tick();
    total++;
    if (bram_state !== BRAM_IDLE) begin bad++; $display("[TB] FAIL idle_after_reset got=%0d want=%0d", bram_state, BRAM_IDLE); end
  endtask

  task automatic test_capture();
    int h, v, seen_writes, errs;
    logic [23:0] pix;
    fsm_state = SAVE_TO_BRAM;
    cur_h = 7; cur_v = 3;
    for (int i = 0; i < 5; i++) drive_pixel(rand_pix(), h, v);
    store_bram = 1'b1;
    while (!(cur_h == 0 && cur_v == 0)) begin
      drive_pixel(rand_pix(), h, v);
      total++;
      if (bram_we !== 1'b0) begin bad++; $display("[TB] FAIL pre_frame_we at (%0d,%0d) got=%b want=0", h, v, bram_we); end
    end
    drive_pixel(24'hFF8040, h, v);
    exp_mem[0] = rgb332(24'hFF8040);
    total++;
    if ({bram_we, bram_addr, bram_din} !== {1'b1, {AW{1'b0}}, 8'hF1})
      begin bad++; $display("[TB] FAIL first_write got we=%b addr=%0d din=%h want we=1 addr=0 din=f1", bram_we, bram_addr, bram_din); end
    total++;
    if (bram_state !== WRITING_FRAME) begin bad++; $display("[TB] FAIL writing_state got=%0d want=%0d", bram_state, WRITING_FRAME); end
    seen_writes = 1;
    do begin
      pix = rand_pix();
      drive_pixel(pix, h, v);
      seen_writes += int'(bram_we);
      total++;
      if (is_active(h, v)) begin
        exp_mem[v * H + h] = rgb332(pix);
        if ({bram_we, bram_addr, bram_din} !== {1'b1, AW'(v * H + h), rgb332(pix)})
          begin bad++; $display("[TB] FAIL write (%0d,%0d) got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h",
                                h, v, bram_we, bram_addr, bram_din, v * H + h, rgb332(pix)); end
      end else if (bram_we !== 1'b0) begin
        bad++; $display("[TB] FAIL blank_we (%0d,%0d) got=%b want=0", h, v, bram_we);
      end
      if (h == H && v == 2) begin
        hcount = 11'd700;
        tick();
        total++;
        if (bram_we !== 1'b0) begin bad++; $display("[TB] FAIL blank_700_we got=%b want=0", bram_we); end
      end
    end while (!(h == H - 1 && v == V - 1));
    total++;
    if (bram_state !== READING_FRAME) begin bad++; $display("[TB] FAIL reading_state got=%0d want=%0d", bram_state, READING_FRAME); end
    for (int i = 0; i < 4; i++) begin
      drive_pixel(rand_pix(), h, v);
      seen_writes += int'(bram_we);
    end
    total++;
    if (seen_writes != N) begin bad++; $display("[TB] FAIL write_count got=%0d want=%0d", seen_writes, N); end
    errs = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) errs++;
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL frame_content bad_bytes got=%0d want=0", errs); end
  endtask

  task automatic test_readback();
    int h, v;
    bit have_prev, exp_disp;
    logic [7:0] exp_dout;
    fsm_state = SHOW_BRAM;
    load_mem(1'b0);
    have_prev = 1'b0;
    exp_disp = 1'b0;
    exp_dout = '0;
    for (int i = 0; i < HT * VT; i++) begin
      drive_pixel(rand_pix(), h, v);
      if (have_prev) begin
        total++;
        if (in_display !== exp_disp) begin bad++; $display("[TB] FAIL in_display i=%0d got=%b want=%b", i, in_display, exp_disp); end
        if (exp_disp) begin
          total++;
          if (bram_dout !== exp_dout) begin bad++; $display("[TB] FAIL readback i=%0d got=%h want=%h", i, bram_dout, exp_dout); end
        end
      end
      exp_disp = is_active(h, v);
      exp_dout = 8'(v * H + h);
      have_prev = 1'b1;
    end
  endtask

  task automatic test_send();
    int idx, cycles, base;
    bit stalled;
    logic [7:0] held;
    load_mem(1'b1);
    hcount = 11'(H + 1);
    base = done_pulses;
    tx_ready = 1'b0;
    fsm_state = SEND_TO_PC;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (tx_valid !== (i == 2)) begin bad++; $display("[TB] FAIL first_valid cycle=%0d got=%b want=%b", i + 1, tx_valid, i == 2); end
    end
    idx = 0; cycles = 0; stalled = 1'b0; held = '0;
    while (idx < N && cycles < 20 * N) begin
      if (stalled) begin
        total++;
        if ({tx_valid, tx_data} !== {1'b1, held})
          begin bad++; $display("[TB] FAIL stall_hold got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, held); end
      end
      tx_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          total++;
          if (tx_data !== load_buf[idx]) begin bad++; $display("[TB] FAIL byte %0d got=%h want=%h", idx, tx_data, load_buf[idx]); end
          idx++;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
      tick();
      cycles++;
    end
    tx_ready = 1'b0;
    total++;
    if (idx != N) begin bad++; $display("[TB] FAIL stream_timeout got=%0d want=%0d bytes", idx, N); end
    total++;
    if (tx_done !== 1'b1) begin bad++; $display("[TB] FAIL done_after_last got=%b want=1", tx_done); end
    repeat (5) tick();
    total++;
    if (done_pulses - base != 1) begin bad++; $display("[TB] FAIL done_pulses got=%0d want=1", done_pulses - base); end
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_after_done got=%b want=0", tx_valid); end
  endtask

  task automatic test_abort();
    int idx, cycles, base;
    fsm_state = SHOW_BRAM;
    repeat (2) tick();
    base = done_pulses;
    fsm_state = SEND_TO_PC;
    repeat (3) tick();
    idx = 0; cycles = 0;
    while (cycles < 20 * N && !(idx >= N / 2 && tx_valid === 1'b1)) begin
      tx_ready = (idx < N / 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tx_valid === 1'b1 && tx_ready) idx++;
      tick();
      cycles++;
    end
    tx_ready = 1'b0;
    total++;
    if (tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL abort_setup got valid=%b want=1", tx_valid); end
    fsm_state = SHOW_BRAM;
    tick();
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid_drop got=%b want=0", tx_valid); end
    tick();
    fsm_state = SEND_TO_PC;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      cycles = 0;
      while (tx_valid !== 1'b1 && cycles < 10) begin tick(); cycles++; end
      total++;
      if ({tx_valid, tx_data} !== {1'b1, load_buf[i]})
        begin bad++; $display("[TB] FAIL restart_byte %0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, load_buf[i]); end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    fsm_state = SHOW_BRAM;
    repeat (3) tick();
    total++;
    if (done_pulses != base) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", done_pulses - base); end
  endtask

  task automatic test_store_drop();
    int h, v;
    store_bram = 1'b0;
    tick();
    total++;
    if (bram_state !== BRAM_IDLE) begin bad++; $display("[TB] FAIL drop_from_reading got=%0d want=%0d", bram_state, BRAM_IDLE); end
    fsm_state = SAVE_TO_BRAM;
    store_bram = 1'b1;
    do drive_pixel(rand_pix(), h, v); while (!(cur_v == 3 && cur_h == 2));
    total++;
    if (bram_state !== WRITING_FRAME) begin bad++; $display("[TB] FAIL drop_setup got=%0d want=%0d", bram_state, WRITING_FRAME); end
    store_bram = 1'b0;
    drive_pixel(rand_pix(), h, v);
    total++;
    if ({bram_state, bram_we} !== {BRAM_IDLE, 1'b0})
      begin bad++; $display("[TB] FAIL drop_mid_write got state=%0d we=%b want state=0 we=0", bram_state, bram_we); end
    for (int i = 0; i < 2 * HT; i++) begin
      drive_pixel(rand_pix(), h, v);
      total++;
      if (bram_we !== 1'b0) begin bad++; $display("[TB] FAIL we_after_drop (%0d,%0d) got=%b want=0", h, v, bram_we); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int h, v, cycles, base;
    fsm_state = SAVE_TO_BRAM;
    store_bram = 1'b1;
    cycles = 0;
    while (bram_state !== READING_FRAME && cycles < 3 * HT * VT) begin
      drive_pixel(rand_pix(), h, v);
      cycles++;
    end
    total++;
    if (bram_state !== READING_FRAME) begin bad++; $display("[TB] FAIL recapture got=%0d want=%0d", bram_state, READING_FRAME); end
    fsm_state = SEND_TO_PC;
    for (int i = 0; i < 30; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b0;
    cycles = 0;
    while (tx_valid !== 1'b1 && cycles < 10) begin tick(); cycles++; end
    total++;
    if (tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL reset_setup got valid=%b want=1", tx_valid); end
    base = done_pulses;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bram_state, bram_addr, bram_din, bram_we, in_display, tx_valid, tx_data, tx_done} !==
        {BRAM_IDLE, {AW{1'b0}}, 8'h00, 4'b0000, 8'h00, 1'b0})
      begin bad++; $display("[TB] FAIL async_reset got state=%0d addr=%0d din=%h we=%b disp=%b txv=%b txd=%h done=%b want all zero",
                            bram_state, bram_addr, bram_din, bram_we, in_display, tx_valid, tx_data, tx_done); end
    repeat (3) tick();
    total++;
    if (done_pulses != base) begin bad++; $display("[TB] FAIL reset_no_done got=%0d want=0", done_pulses - base); end
    reset_n = 1'b1;
    fsm_state = SHOW_BRAM;
    tick();
    total++;
    if (bram_state !== BRAM_IDLE) begin bad++; $display("[TB] FAIL idle_after_release got=%0d want=%0d", bram_state, BRAM_IDLE); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_readback();
    test_send();
    test_abort();
    test_store_drop();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
